// File: rtl/eth_pkg.sv
// Shared RMII MAC definitions: line symbols, field sizes, CRC constants and receiver states.
package eth_pkg;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
    localparam logic [31:0] FCS_RESIDUE    = 32'hDEBB20E3;

    localparam int unsigned DEST_DIBITS  = 24;
    localparam int unsigned SRC_DIBITS   = 24;
    localparam int unsigned ETYPE_DIBITS = 8;
    localparam int unsigned FCS_DIBITS   = 16;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DEST,
        SRC,
        ETYPE,
        PAYLOAD,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/crc32_dibit.sv
// Reflected CRC-32 register advancing two bits per clock, rxd[0]/d[0] first.
module crc32_dibit
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    function automatic logic [31:0] bit_step(input logic [31:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = '1;
        end else if (en) begin
            crc_d = bit_step(bit_step(crc_q, d[0]), d[1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ethernet_rx.sv
// RMII receive front end: preamble/SFD hunt, address filter, header capture, FCS-stripped payload.
//   state     | meaning
//   IDLE      | line quiet; first carrier dibit is judged as preamble
//   PREAMBLE  | counting 01 dibits, 11 after >=4 of them is the SFD
//   DEST      | 24 dibits compared against my_mac and broadcast
//   SRC       | 24 dibits captured into src_mac
//   ETYPE     | 8 dibits captured into etype
//   PAYLOAD   | dibits pass through a 16-deep delay line until carrier drops
//   WAIT_IDLE | frame rejected, silent until carrier drops
module ethernet_rx #(
    parameter int unsigned N           = 2,
    parameter logic [31:0] FCS_RESIDUE = 32'hDEBB20E3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         crsdv,
    input  logic [N-1:0] rxd,
    input  logic [47:0]  my_mac,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic [47:0]  src_mac,
    output logic [15:0]  etype,
    output logic         done,
    output logic         fcs_ok
);
    import eth_pkg::*;

    localparam logic [4:0] DEST_LAST  = 5'(DEST_DIBITS - 1);
    localparam logic [4:0] SRC_LAST   = 5'(SRC_DIBITS - 1);
    localparam logic [4:0] ETYPE_LAST = 5'(ETYPE_DIBITS - 1);
    localparam logic [4:0] DL_FULL    = 5'(FCS_DIBITS);
    localparam logic [4:0] MIN_PRE    = 5'd4;

    rx_state_t                  state_q;
    logic [4:0]                 cnt_q;
    logic                       armed_q;
    logic                       match_q;
    logic                       bcast_q;
    logic [4:0]                 fill_q;
    logic [1:0]                 align_q;
    logic [2*FCS_DIBITS-1:0]    dl_q;
    logic                       axiov_q;
    logic [N-1:0]               axiod_q;
    logic [47:0]                src_mac_q;
    logic [15:0]                etype_q;
    logic                       done_q;
    logic                       fcs_ok_q;

    logic [5:0]  mac_off;
    logic [3:0]  et_off;
    logic        dest_match;
    logic        dest_bcast;
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc;

    // Fields arrive first byte first, each byte LSB dibit first.
    assign mac_off    = {3'd5 - cnt_q[4:2], 3'b000} + {3'b000, cnt_q[1:0], 1'b0};
    assign et_off     = {~cnt_q[2], cnt_q[1:0], 1'b0};
    assign dest_match = match_q && (rxd == my_mac[mac_off +: 2]);
    assign dest_bcast = bcast_q && (rxd == BCAST_MAC[mac_off +: 2]);

    assign crc_init = (state_q == PREAMBLE) && crsdv && (rxd == SFD_DIBIT) && (cnt_q >= MIN_PRE);
    assign crc_en   = crsdv && (state_q inside {DEST, SRC, ETYPE, PAYLOAD});

    crc32_dibit u_crc (
        .clk  (clk),
        .rstn (rstn),
        .init (crc_init),
        .en   (crc_en),
        .d    (rxd),
        .crc  (crc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            match_q   <= 1'b0;
            bcast_q   <= 1'b0;
            fill_q    <= '0;
            align_q   <= '0;
            dl_q      <= '0;
            axiov_q   <= 1'b0;
            axiod_q   <= '0;
            src_mac_q <= '0;
            etype_q   <= '0;
            done_q    <= 1'b0;
            fcs_ok_q  <= 1'b0;
        end else begin
            axiov_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // armed_q blocks a hunt that would start mid-frame after reset
                    if (!crsdv) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        cnt_q   <= 5'd1;
                        state_q <= (rxd == PREAMBLE_DIBIT) ? PREAMBLE : WAIT_IDLE;
                    end
                end
                PREAMBLE: begin
                    if (!crsdv) begin
                        state_q <= IDLE;
                    end else if (rxd == PREAMBLE_DIBIT) begin
                        if (cnt_q < MIN_PRE) cnt_q <= cnt_q + 5'd1;
                    end else if (crc_init) begin
                        state_q <= DEST;
                        cnt_q   <= '0;
                        match_q <= 1'b1;
                        bcast_q <= 1'b1;
                    end else begin
                        state_q <= WAIT_IDLE;
                    end
                end
                DEST: begin
                    if (!crsdv) begin
                        state_q <= IDLE;
                    end else if (cnt_q == DEST_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (dest_match || dest_bcast) ? SRC : WAIT_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 5'd1;
                        match_q <= dest_match;
                        bcast_q <= dest_bcast;
                    end
                end
                SRC, ETYPE: begin
                    if (!crsdv) begin
                        done_q   <= 1'b1;
                        fcs_ok_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (state_q == SRC) begin
                        src_mac_q[mac_off +: 2] <= rxd;
                        cnt_q   <= (cnt_q == SRC_LAST) ? 5'd0 : cnt_q + 5'd1;
                        state_q <= (cnt_q == SRC_LAST) ? ETYPE : SRC;
                    end else begin
                        etype_q[et_off +: 2] <= rxd;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == ETYPE_LAST) begin
                            state_q <= PAYLOAD;
                            fill_q  <= '0;
                            align_q <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!crsdv) begin
                        done_q   <= 1'b1;
                        fcs_ok_q <= (fill_q == DL_FULL) && (align_q == 2'd0) && (crc == FCS_RESIDUE);
                        state_q  <= IDLE;
                    end else begin
                        dl_q    <= {dl_q[2*FCS_DIBITS-3:0], rxd};
                        align_q <= align_q + 2'd1;
                        if (fill_q == DL_FULL) begin
                            axiov_q <= 1'b1;
                            axiod_q <= dl_q[2*FCS_DIBITS-1 -: 2];
                        end else begin
                            fill_q <= fill_q + 5'd1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!crsdv) state_q <= IDLE;
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign axiov   = axiov_q;
    assign axiod   = axiod_q;
    assign src_mac = src_mac_q;
    assign etype   = etype_q;
    assign done    = done_q;
    assign fcs_ok  = fcs_ok_q;

endmodule

// File: tb/tb_ethernet_rx.sv
// Directed frames for ethernet_rx, checked every cycle against a frame-level reference model.
module tb_ethernet_rx;

    typedef logic [7:0] bq_t[$];
    typedef logic [1:0] dq_t[$];

    logic        clk;
    logic        rstn;
    logic        crsdv;
    logic [1:0]  rxd;
    logic [47:0] my_mac;
    logic        axiov;
    logic [1:0]  axiod;
    logic [47:0] src_mac;
    logic [15:0] etype;
    logic        done;
    logic        fcs_ok;

    logic        exp_v;
    logic [1:0]  exp_d;
    logic        exp_done;
    logic        exp_fcs;

    int          n_chk;
    int          n_err;
    int          done_cnt;
    dq_t         cap;

    dq_t         wq;
    int          pl;
    bit          pre_good;
    logic [47:0] cur_dst;

    ethernet_rx #(.N(2), .FCS_RESIDUE(32'hDEBB20E3)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .crsdv  (crsdv),
        .rxd    (rxd),
        .my_mac (my_mac),
        .axiov  (axiov),
        .axiod  (axiod),
        .src_mac(src_mac),
        .etype  (etype),
        .done   (done),
        .fcs_ok (fcs_ok)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Plain byte-wise Ethernet CRC-32 over the first n bytes (init all-ones, final invert).
    function automatic logic [31:0] crc32(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // A frame passes when its payload+FCS is whole bytes, at least 4 bytes long, and the trailing 4 bytes equal the CRC of the rest.
    function automatic bit fcs_model(input dq_t w, input int p);
        bq_t b;
        int  m;
        int  nb;
        m = w.size() - p - 56;
        if (m < 16 || (m % 4) != 0) return 1'b0;
        nb = (w.size() - p) / 4;
        for (int k = 0; k < nb; k++) b.push_back({w[p+4*k+3], w[p+4*k+2], w[p+4*k+1], w[p+4*k]});
        return crc32(b, nb - 4) == {b[nb-1], b[nb-2], b[nb-3], b[nb-4]};
    endfunction

    function automatic dq_t make_pre(input int n01);
        dq_t q;
        for (int i = 0; i < n01; i++) q.push_back(2'b01);
        q.push_back(2'b11);
        return q;
    endfunction

    task automatic build(input dq_t pre, input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] et, input bq_t pay, input int corrupt,
                         input logic [7:0] cval, input int keep, input int extra);
        bq_t         fb;
        logic [31:0] c;
        for (int i = 5; i >= 0; i--) fb.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(src[8*i +: 8]);
        fb.push_back(et[15:8]);
        fb.push_back(et[7:0]);
        foreach (pay[i]) fb.push_back(pay[i]);
        c = crc32(fb, fb.size());
        for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
        if (corrupt >= 0) fb[14+corrupt] = cval;
        wq = pre;
        foreach (fb[i]) for (int j = 0; j < 4; j++) wq.push_back(fb[i][2*j +: 2]);
        if (keep >= 0) while (wq.size() > keep) void'(wq.pop_back());
        for (int i = 0; i < extra; i++) wq.push_back(2'b10);
        pl = pre.size();
        pre_good = (pl >= 5) && (pre[pl-1] == 2'b11);
        for (int i = 0; i < pl - 1; i++) if (pre[i] != 2'b01) pre_good = 1'b0;
        cur_dst = dst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            crsdv = 1'b0; rxd = 2'b00; rstn = 1'b1;
            exp_v = 1'b0; exp_done = 1'b0;
        end
    endtask

    task automatic send(input int rst_at, input int gap);
        bit acc;
        bit ab;
        int n;
        n = wq.size();
        ab = 1'b0;
        acc = pre_good && (cur_dst == my_mac || cur_dst == 48'hFFFF_FFFF_FFFF);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            crsdv = 1'b1; rxd = wq[i];
            rstn = (i == rst_at) ? 1'b0 : 1'b1;
            exp_done = 1'b0;
            if (i == rst_at) begin
                ab = 1'b1;
                exp_fcs = 1'b0;
            end
            exp_v = acc && !ab && (i - pl - 56 >= 16);
            exp_d = exp_v ? wq[i-16] : 2'b00;
        end
        @(negedge clk);
        crsdv = 1'b0; rxd = 2'b00; rstn = 1'b1; exp_v = 1'b0;
        exp_done = acc && !ab && (n - pl >= 24);
        if (exp_done) exp_fcs = fcs_model(wq, pl);
        idle(gap);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("axiov", 64'(axiov), 64'(exp_v));
            if (exp_v) chk("axiod", 64'(axiod), 64'(exp_d));
            chk("done", 64'(done), 64'(exp_done));
            chk("fcs_ok", 64'(fcs_ok), 64'(exp_fcs));
            if (axiov) cap.push_back(axiod);
            if (done) done_cnt++;
        end
    end

    initial begin
        bq_t         pay;
        bq_t         pay8;
        bq_t         txt;
        dq_t         std_pre;
        dq_t         bad_pre;
        int          d0;
        logic [47:0] src1;
        logic [47:0] src2;
        logic [47:0] uni;

        n_chk = 0; n_err = 0; done_cnt = 0;
        rstn = 1'b0; crsdv = 1'b0; rxd = 2'b00;
        exp_v = 1'b0; exp_d = 2'b00; exp_done = 1'b0; exp_fcs = 1'b0;
        uni  = 48'h1234_5678_90AB;
        src1 = 48'h0A1B_2C3D_4E5F;
        src2 = 48'h6655_4433_2211;
        my_mac = uni;
        pay  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pay8 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        txt  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        std_pre = make_pre(31);

        repeat (3) @(negedge clk);
        chk("reset_axiov", 64'(axiov), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_fcs_ok", 64'(fcs_ok), 64'd0);
        chk("reset_src_mac", 64'(src_mac), 64'd0);
        chk("reset_etype", 64'(etype), 64'd0);
        chk("model_crc_pin", 64'(crc32(txt, 9)), 64'hCBF43926);
        idle(2);

        // Broadcast frame
        build(std_pre, 48'hFFFF_FFFF_FFFF, src1, 16'h0800, pay, -1, 8'h00, -1, 0);
        cap.delete(); d0 = done_cnt;
        send(-1, 3);
        chk("bcast_count", 64'(cap.size()), 64'd16);
        if (cap.size() >= 4) begin
            chk("bcast_d0", 64'(cap[0]), 64'd2);
            chk("bcast_d1", 64'(cap[1]), 64'd3);
            chk("bcast_d2", 64'(cap[2]), 64'd1);
            chk("bcast_d3", 64'(cap[3]), 64'd3);
        end
        chk("bcast_done", 64'(done_cnt - d0), 64'd1);
        chk("bcast_fcs_ok", 64'(fcs_ok), 64'd1);
        chk("bcast_etype", 64'(etype), 64'h0800);
        chk("bcast_src", 64'(src_mac), 64'h0A1B_2C3D_4E5F);

        // Unicast hit
        build(std_pre, uni, src2, 16'h0800, pay, -1, 8'h00, -1, 0);
        cap.delete(); d0 = done_cnt;
        send(-1, 3);
        chk("uni_count", 64'(cap.size()), 64'd16);
        chk("uni_done", 64'(done_cnt - d0), 64'd1);
        chk("uni_fcs_ok", 64'(fcs_ok), 64'd1);
        chk("uni_src", 64'(src_mac), 64'h6655_4433_2211);

        // Unicast miss leaves everything untouched
        my_mac = 48'h1234_5678_90AC;
        build(std_pre, uni, src1, 16'h86DD, pay, -1, 8'h00, -1, 0);
        cap.delete(); d0 = done_cnt;
        send(-1, 3);
        chk("miss_count", 64'(cap.size()), 64'd0);
        chk("miss_done", 64'(done_cnt - d0), 64'd0);
        chk("miss_src", 64'(src_mac), 64'h6655_4433_2211);
        chk("miss_etype", 64'(etype), 64'h0800);
        my_mac = uni;

        // Corrupted payload byte
        build(std_pre, uni, src1, 16'h0800, pay, 0, 8'h5E, -1, 0);
        cap.delete(); d0 = done_cnt;
        send(-1, 3);
        chk("bad_count", 64'(cap.size()), 64'd16);
        if (cap.size() >= 4) begin
            chk("bad_d0", 64'(cap[0]), 64'd2);
            chk("bad_d1", 64'(cap[1]), 64'd3);
            chk("bad_d2", 64'(cap[2]), 64'd1);
            chk("bad_d3", 64'(cap[3]), 64'd1);
        end
        chk("bad_done", 64'(done_cnt - d0), 64'd1);
        chk("bad_fcs_ok", 64'(fcs_ok), 64'd0);

        // Preamble boundaries
        d0 = done_cnt;
        build(make_pre(2), uni, src1, 16'h0800, pay, -1, 8'h00, -1, 0);
        send(-1, 2);
        build(make_pre(3), uni, src1, 16'h0800, pay, -1, 8'h00, -1, 0);
        send(-1, 2);
        bad_pre = make_pre(31);
        bad_pre[10] = 2'b00;
        build(bad_pre, uni, src1, 16'h0800, pay, -1, 8'h00, -1, 0);
        send(-1, 2);
        chk("pre_reject_done", 64'(done_cnt - d0), 64'd0);
        build(make_pre(4), uni, src1, 16'h0800, pay, -1, 8'h00, -1, 0);
        send(-1, 2);
        chk("pre_min_done", 64'(done_cnt - d0), 64'd1);
        chk("pre_min_fcs_ok", 64'(fcs_ok), 64'd1);

        // Reset mid-payload, then a clean frame
        build(std_pre, uni, src1, 16'h0800, pay, -1, 8'h00, -1, 0);
        d0 = done_cnt;
        send(32 + 56 + 20, 2);
        chk("rst_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_src", 64'(src_mac), 64'd0);
        chk("rst_etype", 64'(etype), 64'd0);
        build(std_pre, uni, src2, 16'h88B5, pay, -1, 8'h00, -1, 0);
        send(-1, 2);
        chk("post_rst_done", 64'(done_cnt - d0), 64'd1);
        chk("post_rst_fcs_ok", 64'(fcs_ok), 64'd1);
        chk("post_rst_etype", 64'(etype), 64'h88B5);

        // Back-to-back with a single quiet cycle between
        cap.delete(); d0 = done_cnt;
        build(std_pre, 48'hFFFF_FFFF_FFFF, src1, 16'h0800, pay, -1, 8'h00, -1, 0);
        send(-1, 0);
        build(std_pre, uni, src2, 16'h0806, pay8, -1, 8'h00, -1, 0);
        send(-1, 3);
        chk("b2b_count", 64'(cap.size()), 64'd48);
        chk("b2b_done", 64'(done_cnt - d0), 64'd2);
        chk("b2b_etype", 64'(etype), 64'h0806);

        // Runts and misalignment
        cap.delete(); d0 = done_cnt;
        build(std_pre, uni, src1, 16'h0800, pay, -1, 8'h00, 32 + 53, 0);
        send(-1, 2);
        chk("runt_etype_done", 64'(done_cnt - d0), 64'd1);
        chk("runt_etype_fcs", 64'(fcs_ok), 64'd0);
        build(std_pre, uni, src1, 16'h0800, pay, -1, 8'h00, 32 + 56 + 8, 0);
        send(-1, 2);
        chk("runt_short_done", 64'(done_cnt - d0), 64'd2);
        chk("runt_count", 64'(cap.size()), 64'd0);
        build(std_pre, uni, src1, 16'h0800, pay, -1, 8'h00, -1, 1);
        send(-1, 3);
        chk("misalign_done", 64'(done_cnt - d0), 64'd3);
        chk("misalign_fcs", 64'(fcs_ok), 64'd0);
        chk("misalign_count", 64'(cap.size()), 64'd17);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
